// File: rtl/sar_search_4bit_pkg.sv
// Shared types and defaults for the successive-approximation search block.
package sar_search_4bit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT  = 2'b01,
    ST_TRIAL = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_CMP_WAIT = 0;

  // A trustworthy comparator asserts exactly one of its three flags.
  function automatic logic flags_onehot(input logic eq, input logic gt, input logic lt);
    logic ok;
    case ({eq, gt, lt})
      3'b100, 3'b010, 3'b001: ok = 1'b1;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/sar_search_4bit_if.sv
// Search request/result bundle plus the external comparator flags.
interface sar_search_4bit_if import sar_search_4bit_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] guess;
  logic             cmp_equal;
  logic             cmp_greater;
  logic             cmp_lesser;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             exact;
  logic             error;

  modport master (
    output start, cmp_equal, cmp_greater, cmp_lesser,
    input  guess, busy, done, result, exact, error
  );

  modport slave (
    input  start, cmp_equal, cmp_greater, cmp_lesser,
    output guess, busy, done, result, exact, error
  );

endinterface

// File: rtl/sar_search_4bit_step.sv
// One successive-approximation step: resolve the current bit from the flags
// and pre-set the next lower bit.
module sar_step import sar_search_4bit_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDX_W = $clog2(DEF_WIDTH)
) (
  input  logic [WIDTH-1:0] guess,
  input  logic [IDX_W-1:0] index,
  input  logic             cmp_equal,
  input  logic             cmp_greater,
  input  logic             cmp_lesser,
  output logic [WIDTH-1:0] adj_guess,
  output logic [WIDTH-1:0] next_guess,
  output logic [IDX_W-1:0] next_index,
  output logic             flags_ok,
  output logic             last_bit
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] mask_s;

  // Bit resolution and next-trial value.
  always_comb begin
    mask_s   = ONE << index;
    flags_ok = flags_onehot(cmp_equal, cmp_greater, cmp_lesser);
    last_bit = (index == IDX_W'(0));
    if (cmp_greater) begin
      adj_guess = guess & ~mask_s;
    end else begin
      adj_guess = guess;
    end
    if (!last_bit) begin
      next_guess = adj_guess | (mask_s >> 1);
      next_index = index - IDX_W'(1);
    end else begin
      next_guess = adj_guess;
      next_index = index;
    end
  end

endmodule

// File: rtl/sar_search_4bit.sv
// Successive-approximation search driving an external magnitude comparator;
// FSM, settle counter and result registers live here, bit arithmetic in sar_step.
module sar_search_4bit import sar_search_4bit_pkg::*; #(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CMP_WAIT = DEF_CMP_WAIT
) (
  input logic             clk,
  input logic             rst,
  sar_search_4bit_if.slave bus
);

  localparam int               IDX_W       = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MSB_ONLY    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [IDX_W-1:0] IDX_TOP     = IDX_W'(WIDTH - 1);
  localparam int               WAIT_LOAD_I = (CMP_WAIT > 0) ? CMP_WAIT - 1 : 0;
  localparam logic [1:0]       WAIT_LOAD   = 2'(WAIT_LOAD_I);
  // With no settle time the comparator flags are already valid on entry.
  localparam state_t           TRIAL_ENTRY = (CMP_WAIT == 0) ? ST_TRIAL : ST_WAIT;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] guess_r, guess_s;
  logic [IDX_W-1:0] idx_r, idx_s;
  logic [1:0]       cnt_r, cnt_s;
  logic [WIDTH-1:0] result_r, result_s;
  logic             exact_r, exact_s;
  logic             error_r, error_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;

  logic [WIDTH-1:0] adj_guess_s;
  logic [WIDTH-1:0] step_guess_s;
  logic [IDX_W-1:0] step_index_s;
  logic             flags_ok_s;
  logic             last_bit_s;

  sar_step #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_step (
    .guess       (guess_r),
    .index       (idx_r),
    .cmp_equal   (bus.cmp_equal),
    .cmp_greater (bus.cmp_greater),
    .cmp_lesser  (bus.cmp_lesser),
    .adj_guess   (adj_guess_s),
    .next_guess  (step_guess_s),
    .next_index  (step_index_s),
    .flags_ok    (flags_ok_s),
    .last_bit    (last_bit_s)
  );

  // Next-state and next-register values; everything holds unless a case moves it.
  always_comb begin
    state_s  = state_r;
    guess_s  = guess_r;
    idx_s    = idx_r;
    cnt_s    = cnt_r;
    result_s = result_r;
    exact_s  = exact_r;
    error_s  = error_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_s  = TRIAL_ENTRY;
          guess_s  = MSB_ONLY;
          idx_s    = IDX_TOP;
          cnt_s    = WAIT_LOAD;
          result_s = {WIDTH{1'b0}};
          exact_s  = 1'b0;
          error_s  = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 2'd0) begin
          state_s = ST_TRIAL;
        end else begin
          cnt_s = cnt_r - 2'd1;
        end
      end
      ST_TRIAL: begin
        if (!flags_ok_s) begin
          state_s  = ST_DONE;
          result_s = guess_r;
          error_s  = 1'b1;
        end else if (bus.cmp_equal) begin
          state_s  = ST_DONE;
          result_s = guess_r;
          exact_s  = 1'b1;
        end else if (last_bit_s) begin
          state_s  = ST_DONE;
          guess_s  = adj_guess_s;
          result_s = adj_guess_s;
        end else begin
          state_s = TRIAL_ENTRY;
          guess_s = step_guess_s;
          idx_s   = step_index_s;
          cnt_s   = WAIT_LOAD;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s == ST_WAIT) || (state_s == ST_TRIAL);
    done_s = (state_s == ST_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      guess_r  <= {WIDTH{1'b0}};
      idx_r    <= {IDX_W{1'b0}};
      cnt_r    <= 2'd0;
      result_r <= {WIDTH{1'b0}};
      exact_r  <= 1'b0;
      error_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      guess_r  <= guess_s;
      idx_r    <= idx_s;
      cnt_r    <= cnt_s;
      result_r <= result_s;
      exact_r  <= exact_s;
      error_r  <= error_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end

  assign bus.guess  = guess_r;
  assign bus.result = result_r;
  assign bus.exact  = exact_r;
  assign bus.error  = error_r;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;

endmodule

// File: tb/tb_sar_search_4bit.sv
// Directed bench: two instances (CMP_WAIT 0 and 2) fed by a 4-bit magnitude
// comparator model with a flag-override for fault injection.
module tb_sar_search_4bit;
  import sar_search_4bit_pkg::*;

  typedef struct {
    int         sel;
    logic [3:0] target;
    logic [3:0] g0, g1, g2, g3;
    int         lat;
    logic [3:0] res;
    logic       exact;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       start_s;
  int         sel;
  logic [3:0] target;
  logic       force_en;
  logic [2:0] force_val;
  int         n_cmp;
  int         n_bad;

  sar_search_4bit_if #(.WIDTH(4)) bus0 ();
  sar_search_4bit_if #(.WIDTH(4)) bus2 ();

  sar_search_4bit #(.WIDTH(4), .CMP_WAIT(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  sar_search_4bit #(.WIDTH(4), .CMP_WAIT(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  function automatic logic [2:0] cmp4(input logic [3:0] a, input logic [3:0] b);
    return {a == b, a > b, a < b};
  endfunction

  assign bus0.start = start_s && (sel == 0);
  assign bus2.start = start_s && (sel == 1);
  assign {bus0.cmp_equal, bus0.cmp_greater, bus0.cmp_lesser} =
    force_en ? force_val : cmp4(bus0.guess, target);
  assign {bus2.cmp_equal, bus2.cmp_greater, bus2.cmp_lesser} =
    force_en ? force_val : cmp4(bus2.guess, target);

  logic [3:0] cur_guess, cur_result;
  logic       cur_busy, cur_done, cur_exact, cur_error;
  assign cur_guess  = (sel == 1) ? bus2.guess  : bus0.guess;
  assign cur_result = (sel == 1) ? bus2.result : bus0.result;
  assign cur_busy   = (sel == 1) ? bus2.busy   : bus0.busy;
  assign cur_done   = (sel == 1) ? bus2.done   : bus0.done;
  assign cur_exact  = (sel == 1) ? bus2.exact  : bus0.exact;
  assign cur_error  = (sel == 1) ? bus2.error  : bus0.error;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_guess"},  cur_guess,  0);
    chk({tag, "_result"}, cur_result, 0);
    chk({tag, "_busy"},   cur_busy,   0);
    chk({tag, "_done"},   cur_done,   0);
    chk({tag, "_exact"},  cur_exact,  0);
    chk({tag, "_error"},  cur_error,  0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [3:0] eg[4];
    int w, n, idx;
    logic got_done;
    eg[0] = v.g0; eg[1] = v.g1; eg[2] = v.g2; eg[3] = v.g3;
    w = (v.sel == 1) ? 2 : 0;
    sel = v.sel;
    target = v.target;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    n = 0;
    got_done = 1'b0;
    while (!got_done && n < 40) begin
      if (cur_done) begin
        got_done = 1'b1;
      end else begin
        idx = n / (1 + w);
        if (idx > 3) idx = 3;
        chk({tag, "_busy"},  cur_busy, 1);
        chk({tag, "_guess"}, cur_guess, eg[idx]);
        tick();
        n++;
      end
    end
    chk({tag, "_done_seen"}, got_done, 1);
    chk({tag, "_latency"}, n + 1, v.lat);
    chk({tag, "_result"},  cur_result, v.res);
    chk({tag, "_exact"},   cur_exact, v.exact);
    chk({tag, "_error"},   cur_error, 0);
    chk({tag, "_busy_done"}, cur_busy, 0);
    chk({tag, "_guess_done"}, cur_guess, v.res);
    tick();
    chk({tag, "_done_pulse"}, cur_done, 0);
    chk({tag, "_result_held"}, cur_result, v.res);
    chk({tag, "_exact_held"}, cur_exact, v.exact);
    chk({tag, "_guess_idle"}, cur_guess, v.res);
  endtask

  vec_t vecs[11];

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; start_s = 1'b0; sel = 0; target = 4'd0;
    force_en = 1'b0; force_val = 3'b000;

    vecs[0]  = '{0, 4'd5,  4'd8, 4'd4,  4'd6,  4'd5,  5,  4'd5,  1'b1};
    vecs[1]  = '{0, 4'd0,  4'd8, 4'd4,  4'd2,  4'd1,  5,  4'd0,  1'b0};
    vecs[2]  = '{0, 4'd15, 4'd8, 4'd12, 4'd14, 4'd15, 5,  4'd15, 1'b1};
    vecs[3]  = '{0, 4'd8,  4'd8, 4'd0,  4'd0,  4'd0,  2,  4'd8,  1'b1};
    vecs[4]  = '{0, 4'd10, 4'd8, 4'd12, 4'd10, 4'd0,  4,  4'd10, 1'b1};
    vecs[5]  = '{0, 4'd1,  4'd8, 4'd4,  4'd2,  4'd1,  5,  4'd1,  1'b1};
    vecs[6]  = '{1, 4'd15, 4'd8, 4'd12, 4'd14, 4'd15, 13, 4'd15, 1'b1};
    vecs[7]  = '{1, 4'd5,  4'd8, 4'd4,  4'd6,  4'd5,  13, 4'd5,  1'b1};
    vecs[8]  = '{1, 4'd7,  4'd8, 4'd4,  4'd6,  4'd7,  13, 4'd7,  1'b1};
    vecs[9]  = '{1, 4'd0,  4'd8, 4'd4,  4'd2,  4'd1,  13, 4'd0,  1'b0};
    vecs[10] = '{1, 4'd8,  4'd8, 4'd0,  4'd0,  4'd0,  4,  4'd8,  1'b1};

    tick(); tick();
    sel = 0; #1; chk_all_zero("rst0");
    sel = 1; #1; chk_all_zero("rst2");
    rst = 1'b0;
    sel = 0;
    tick();

    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Illegal flag combinations in the first trial.
    sel = 0; target = 4'd5;
    start_s = 1'b1; tick(); start_s = 1'b0;
    force_en = 1'b1; force_val = 3'b000;
    tick();
    chk("flag000_done", cur_done, 1);
    chk("flag000_error", cur_error, 1);
    chk("flag000_result", cur_result, 8);
    chk("flag000_exact", cur_exact, 0);
    chk("flag000_busy", cur_busy, 0);
    force_en = 1'b0;
    tick();
    chk("flag000_error_held", cur_error, 1);
    start_s = 1'b1; tick(); start_s = 1'b0;
    chk("flag110_error_clr", cur_error, 0);
    force_en = 1'b1; force_val = 3'b110;
    tick();
    chk("flag110_done", cur_done, 1);
    chk("flag110_error", cur_error, 1);
    chk("flag110_result", cur_result, 8);
    force_en = 1'b0;
    tick();

    // Reset in the middle of the second trial, then a fresh search.
    target = 4'd5;
    start_s = 1'b1; tick(); start_s = 1'b0;
    tick();
    chk("midrst_guess2", cur_guess, 4);
    rst = 1'b1;
    tick();
    chk_all_zero("midrst");
    rst = 1'b0;
    begin
      vec_t v9;
      v9 = '{0, 4'd9, 4'd8, 4'd12, 4'd10, 4'd9, 5, 4'd9, 1'b1};
      run_vec(v9, "after_rst");
    end

    // Reset wins over a coincident start.
    rst = 1'b1; start_s = 1'b1;
    tick();
    rst = 1'b0; start_s = 1'b0;
    chk("rst_start_busy", cur_busy, 0);
    chk("rst_start_guess", cur_guess, 0);
    tick();
    chk("rst_start_busy2", cur_busy, 0);

    // start held high through the search and DONE: exactly one done pulse.
    begin
      int dones, cyc;
      target = 4'd5;
      dones = 0;
      cyc = 0;
      start_s = 1'b1;
      tick();
      while (!cur_done && cyc < 20) begin
        tick();
        cyc++;
      end
      chk("hold_done_seen", cur_done, 1);
      if (cur_done) dones++;
      chk("hold_result", cur_result, 5);
      tick();
      start_s = 1'b0;
      chk("hold_no_restart", cur_busy, 0);
      for (int k = 0; k < 4; k++) begin
        if (cur_done) dones++;
        tick();
      end
      chk("hold_one_done", dones, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sar_search_4bit.md
SAR_SEARCH_4BIT -- requirements
Module: sar_search_4bit

Interface
REQ-001 Parameter WIDTH, default 4: search word width; legal range 2..8.
REQ-002 Parameter CMP_WAIT, default 0: extra cycles the comparator flags need to settle after guess changes; legal range 0..3.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  request a new search; sampled only in IDLE.
REQ-006 guess  output  WIDTH  registered trial value; drives the external magnitude comparator b1 input (target on b2).
REQ-007 cmp_equal / cmp_greater / cmp_lesser  input  1 each  comparator flags (guess==target, guess>target, guess<target).
REQ-008 busy  output  1  high while a search is in progress (TRIAL or WAIT state).
REQ-009 done  output  1  one-cycle pulse at search end.
REQ-010 result  output  WIDTH  final value; valid from the done cycle, held until the next accepted start.
REQ-011 exact  output  1  search ended on cmp_equal; held with result.
REQ-012 error  output  1  search aborted on illegal flag combination; held with result.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT, TRIAL, DONE; 2-bit encoding.
REQ-014 IDLE: start=1 -> WAIT (or TRIAL when CMP_WAIT=0); guess <= MSB-only value (WIDTH=4: 4'b1000); bit index <= WIDTH-1; result/exact/error cleared.
REQ-015 WAIT: a down-counter SHALL hold for CMP_WAIT cycles, then -> TRIAL; flags ignored in WAIT.
REQ-016 TRIAL samples flags once. Exactly-one-high required; any other combination -> DONE with error=1, result=guess.
REQ-017 TRIAL, cmp_equal: -> DONE, result=guess, exact=1.
REQ-018 TRIAL, cmp_greater: clear guess[index]; cmp_lesser: keep guess[index].
REQ-019 TRIAL, index>0 and not equal: set guess[index-1], index decrements, -> WAIT/TRIAL.
REQ-020 TRIAL, index=0 and not equal: result = adjusted guess, exact=0, -> DONE.
REQ-021 DONE lasts exactly one cycle: done=1, busy=0, then -> IDLE; start in DONE is ignored.
REQ-022 start while busy SHALL be ignored; no queueing.
REQ-023 Each trial costs 1+CMP_WAIT cycles; worst-case start-to-done latency = WIDTH*(1+CMP_WAIT)+1 cycles.
REQ-024 guess SHALL only change on trial transitions and on start acceptance; it is held through WAIT, DONE, and IDLE.

Reset
REQ-025 rst=1 at any edge, including mid-search, SHALL force IDLE: guess=0, result=0, busy=0, done=0, exact=0, error=0, counters=0.
REQ-026 rst has priority over start when both are asserted in the same cycle; the start is dropped.

Structure
REQ-027 A shared package SHALL hold the state typedef, state encodings, and the default WIDTH/CMP_WAIT constants.
REQ-028 A single sub-module, sar_step, SHALL compute the next guess and next index combinationally from guess, index, and flags; the FSM and counters stay in the top level.
REQ-029 The bench SHALL pair the block with the existing 4-bit comparator as the flag source.

Verification
REQ-030 WIDTH=4, CMP_WAIT=0, target=5, start pulse -> guesses 8,4,6,5; done 5 cycles after start; result=5, exact=1.
REQ-031 target=0 -> guesses 8,4,2,1; done after 4 trials; result=0, exact=0, error=0.
REQ-032 CMP_WAIT=2, target=15 -> each guess held 3 cycles; guesses 8,12,14,15; done ends on equal at the 4th trial; result=15, exact=1.
REQ-033 Flags forced to 3'b000 in the first TRIAL -> done next cycle; error=1, result=8.
REQ-034 rst asserted on the 2nd trial of a search -> next cycle all outputs are 0 and the FSM is in IDLE; a subsequent start with target=9 -> result=9.
REQ-035 start re-pulsed while busy and during DONE -> ignored; exactly one done pulse per accepted start.
